// File: rtl/exec_muldiv.sv
// Iterative integer multiply/divide unit: shift-add MUL and radix-2 restoring DIV/REM,
// one bit per cycle, with valid/ready handshakes, flush and 32-bit word mode.
module exec_muldiv #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             word,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned CNT_W  = 7;
  localparam bit          IS64   = (XLEN == 64);
  localparam int unsigned WSHIFT = IS64 ? 32 : 0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    r1_q, r1_d;   // MUL accumulator / DIV partial remainder
  logic [XLEN-1:0]    r2_q, r2_d;   // MUL multiplicand / DIV divisor magnitude
  logic [XLEN-1:0]    r3_q, r3_d;   // MUL multiplier / DIV dividend shifting into quotient
  logic [2:0]         op_q, op_d;
  logic               word_q, word_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  // Accept-side decode and operand preparation
  logic             word_eff, in_div, in_rem, in_uns;
  logic             a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  a_prep, b_prep, a_mag, b_mag, min_n, spec_res;
  logic [CNT_W-1:0] n_in;

  always_comb begin
    word_eff = IS64 && word;
    in_div   = op[2];
    in_rem   = op[1];
    in_uns   = op[0];
    a_prep   = a;
    b_prep   = b;
    if (word_eff) begin
      a_prep = (in_div && in_uns) ? XLEN'(a[31:0]) : sext32(a[31:0]);
      b_prep = (in_div && in_uns) ? XLEN'(b[31:0]) : sext32(b[31:0]);
    end
    a_neg    = in_div && !in_uns && a_prep[XLEN-1];
    b_neg    = in_div && !in_uns && b_prep[XLEN-1];
    a_mag    = a_neg ? -a_prep : a_prep;
    b_mag    = b_neg ? -b_prep : b_prep;
    min_n    = word_eff ? sext32(32'h8000_0000) : (XLEN'(1) << (XLEN - 1));
    div_zero = in_div && (b_prep == '0);
    div_ovf  = in_div && !in_uns && (a_prep == min_n) && (b_prep == '1);
    n_in     = word_eff ? CNT_W'(32) : CNT_W'(XLEN);
    if (div_zero) begin
      spec_res = in_rem ? a_prep : '1;
    end else begin
      spec_res = in_rem ? '0 : a_prep;
    end
    if (word_eff) begin
      spec_res = sext32(spec_res[31:0]);
    end
  end

  // One iteration step and final sign fix-up
  logic [XLEN-1:0] r1_n, r2_n, r3_n, fin;
  logic [XLEN:0]   shifted, diff;
  logic            q_bit;

  always_comb begin
    shifted = {r1_q, r3_q[XLEN-1]};
    diff    = shifted - {1'b0, r2_q};
    q_bit   = ~diff[XLEN];
    if (op_q[2]) begin
      r1_n = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      r2_n = r2_q;
      r3_n = {r3_q[XLEN-2:0], q_bit};
    end else begin
      r1_n = r1_q + (r3_q[0] ? r2_q : '0);
      r2_n = r2_q << 1;
      r3_n = r3_q >> 1;
    end
    if (!op_q[2]) begin
      fin = r1_n;
    end else if (op_q[1]) begin
      fin = negr_q ? -r1_n : r1_n;
    end else begin
      fin = negq_q ? -r3_n : r3_n;
    end
    if (word_q) begin
      fin = sext32(fin[31:0]);
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    r3_d      = r3_q;
    op_d      = op_q;
    word_d    = word_q;
    tag_d     = tag_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d   = op;
            word_d = word_eff;
            tag_d  = tag_in;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            cnt_d  = n_in;
            if (div_zero || div_ovf) begin
              state_d   = DONE;
              result_d  = spec_res;
              tag_out_d = tag_in;
            end else begin
              state_d = BUSY;
              r1_d    = '0;
              r2_d    = in_div ? b_mag : a_prep;
              if (!in_div) begin
                r3_d = b_prep;
              end else begin
                r3_d = word_eff ? (a_mag << WSHIFT) : a_mag;
              end
            end
          end
        end
        BUSY: begin
          r1_d  = r1_n;
          r2_d  = r2_n;
          r3_d  = r3_n;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = DONE;
            result_d  = fin;
            tag_out_d = tag_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      tag_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      result_q    <= '0;
      tag_out_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      op_q        <= op_d;
      word_q      <= word_d;
      tag_q       <= tag_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      result_q    <= result_d;
      tag_out_q   <= tag_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv (XLEN=64): results, latencies, backpressure, flush, reset.
module tb_exec_muldiv;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 5;
  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             word;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  int n_tests = 0;
  int n_fail  = 0;

  exec_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic wd,
                        input logic [63:0] va, input logic [63:0] vb, input logic [4:0] tg,
                        input logic [63:0] exp_res, input int exp_lat, input bit retire);
    int lat;
    check({name, "/ready_before"}, 64'(in_ready), 64'd1);
    op = o; word = wd; a = va; b = vb; tag_in = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "/latency"}, 64'(lat), 64'(exp_lat));
    check({name, "/result"}, result, exp_res);
    check({name, "/tag"}, 64'(tag_out), 64'(tg));
    if (retire) begin
      @(posedge clk); #1;
      check({name, "/ready_after"}, 64'(in_ready), 64'd1);
      check({name, "/valid_after"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    int pulses;
    reset = 1'b1; in_valid = 1'b0; op = OP_MUL; word = 1'b0; a = '0; b = '0;
    tag_in = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/in_ready", 64'(in_ready), 64'd1);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/result", result, 64'd0);
    check("rst/tag_out", 64'(tag_out), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7x-3", OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b1);
    run_op("divu_by0", OP_DIVU, 1'b0, 64'd100, 64'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1);
    run_op("remu_by0", OP_REMU, 1'b0, 64'd100, 64'd0, 5'd2, 64'd100, 1, 1'b1);
    run_op("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'h8000_0000_0000_0000, 1, 1'b1);
    run_op("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'd0, 1, 1'b1);
    run_op("divw_ovf", OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd6, 64'hFFFF_FFFF_8000_0000, 1, 1'b1);
    run_op("rem_-7_2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);
    run_op("remuw", OP_REMU, 1'b1, 64'hFFFF_FFF9, 64'd2, 5'd8, 64'd1, 33, 1'b1);
    run_op("div_-7_2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b1);
    run_op("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd10, 64'd14, 65, 1'b1);
    run_op("divu_big", OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd11, 64'h0FFF_FFFF_FFFF_FFFF, 65, 1'b1);
    run_op("remu_big", OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd12, 64'hF, 65, 1'b1);
    run_op("mul_m1xm1", OP_MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd1, 65, 1'b1);
    run_op("mulw_sext", OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b1);
    run_op("mulw_wrap", OP_MUL, 1'b1, 64'h1_0000, 64'h1_0000, 5'd15, 64'd0, 33, 1'b1);
    run_op("op011_mul", 3'b011, 1'b0, 64'd6, 64'd7, 5'd16, 64'd42, 65, 1'b1);
    run_op("divw_-7_2", OP_DIV, 1'b1, 64'hFFFF_FFF9, 64'd2, 5'd17, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b1);
    run_op("remw_7_-2", OP_REM, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd18, 64'd1, 33, 1'b1);
    run_op("divuw", OP_DIVU, 1'b1, 64'hFFFF_FFF9, 64'd2, 5'd19, 64'h7FFF_FFFC, 33, 1'b1);
    run_op("remw_by0", OP_REM, 1'b1, 64'h8000_0005, 64'd0, 5'd20, 64'hFFFF_FFFF_8000_0005, 1, 1'b1);

    // Backpressure: result held for several cycles while out_ready is low
    out_ready = 1'b0;
    run_op("bp", OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd9, 64'd14, 65, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp/out_valid", 64'(out_valid), 64'd1);
      check("bp/in_ready", 64'(in_ready), 64'd0);
      check("bp/result", result, 64'd14);
      check("bp/tag", 64'(tag_out), 64'd9);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp/release_ready", 64'(in_ready), 64'd1);
    check("bp/release_valid", 64'(out_valid), 64'd0);

    // Flush in the middle of a divide
    op = OP_DIV; word = 1'b0; a = 64'hFFFF_FFFF_FFFF_FF9C; b = 64'd3; tag_in = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("flush/busy_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush/ready", 64'(in_ready), 64'd1);
    check("flush/valid", 64'(out_valid), 64'd0);
    check("flush/result_held", result, 64'd14);
    pulses = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("flush/no_pulse", 64'(pulses), 64'd0);

    // Flush together with in_valid in IDLE must not accept
    op = OP_DIVU; word = 1'b0; a = 64'd5; b = 64'd0; tag_in = 5'd22; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle/valid", 64'(out_valid), 64'd0);
    check("flush_idle/ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("flush_idle/valid2", 64'(out_valid), 64'd0);

    // Flush while holding a result in DONE
    out_ready = 1'b0;
    run_op("flush_done", OP_DIVU, 1'b0, 64'd5, 64'd0, 5'd23, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    check("flush_done/valid", 64'(out_valid), 64'd0);
    check("flush_done/ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a multiply
    op = OP_MUL; word = 1'b0; a = 64'd3; b = 64'd5; tag_in = 5'd24; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy/ready", 64'(in_ready), 64'd1);
    check("rst_busy/valid", 64'(out_valid), 64'd0);
    check("rst_busy/result", result, 64'd0);
    check("rst_busy/tag", 64'(tag_out), 64'd0);
    pulses = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("rst_busy/no_pulse", 64'(pulses), 64'd0);
    run_op("post_rst_mul", OP_MUL, 1'b0, 64'd3, 64'd5, 5'd25, 64'd15, 65, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
